if_prefetch_stage: RTL
======================

Name: if_prefetch_stage

Overview:
- Parametrised successor to the single-PC fetch stage for the lc3b pipeline.
- Fetches sequential instruction words from the instruction memory port into a DEPTH-entry prefetch queue, one memory request outstanding at a time.
- Presents queue-head packets to decode with a valid/ready handshake.
- Accepts a redirect (branch or writeback target) that flushes the queue and discards any in-flight response.

Parameters:
- DEPTH, 4: prefetch queue entries; power of two, >= 2.
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  flush and restart fetch at redirect_target.
- redirect_target  in  16  new fetch PC (lc3b_word).
- out_ready  in  1  decode accepts the head packet this cycle.
- packet  out  lc3b_ipacket  head-entry packet built from the stored {pc, inst}.
- packet_valid  out  1  head entry valid.
- if_memaddr  out  16  request address.
- if_memread  out  1  read request.
- if_mem_byte_enable  out  2  constant 2'b11.
- if_mem_resp  in  1  one-cycle response strobe.
- if_mem_rdata  in  16  read data, valid when if_mem_resp = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; fpc = RESET_PC; req_addr = RESET_PC; count = 0; rd_ptr = wr_ptr = 0.
  - Outputs: if_memread = 0, packet_valid = 0, if_memaddr = RESET_PC.
  - Queue RAM contents are don't-care.
- Memory protocol:
  - if_memread and if_memaddr are registered (Moore).
  - Once if_memread is raised, both are held stable until the cycle with if_mem_resp = 1.
- FSM states: IDLE, FETCH, DISCARD. if_memread = (state != IDLE).
- Definitions:
  - push = FETCH & if_mem_resp & ~redirect_valid.
  - pop = packet_valid & out_ready.
  - count_next = count + push - pop (or 0 on redirect).
  - next_pc = redirect_valid ? redirect_target : fpc.
- IDLE:
  - If count_next < DEPTH: req_addr <= next_pc, fpc <= next_pc + 2, go to FETCH.
  - Otherwise remain IDLE and apply any redirect to fpc.
- FETCH:
  - On push: write {req_addr, if_mem_rdata} at wr_ptr.
  - If count_next < DEPTH: req_addr <= fpc, fpc <= fpc + 2, stay in FETCH (back-to-back requests). Otherwise go to IDLE.
  - Redirect with no resp this cycle: fpc <= redirect_target, go to DISCARD.
  - Redirect with resp this cycle: drop the data, req_addr <= redirect_target, fpc <= redirect_target + 2, stay in FETCH.
- DISCARD:
  - Hold memread and address; drop rdata on resp.
  - On resp: req_addr <= fpc, fpc <= fpc + 2, go to FETCH.
  - Redirect in DISCARD: fpc <= redirect_target, stay in DISCARD. If resp arrives in the same cycle, the new target is used.
- Redirect (any state):
  - count, rd_ptr and wr_ptr are cleared at the next edge.
  - packet_valid = (count != 0) & ~redirect_valid, so no pop occurs in the redirect cycle.
- Queue:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - The single-outstanding rule plus the launch condition guarantees no push when full and no pop when empty.
  - Simultaneous push and pop leaves count unchanged.
- Arithmetic: all PC arithmetic is 16-bit modulo; 16'hFFFE + 2 wraps to 16'h0000.
- Latency:
  - A resp at edge t gives packet_valid at t+1, even with an empty queue (no bypass).
  - Peak throughput is one instruction per memory response.
- Reset mid-operation: the outstanding request is abandoned; memread drops asynchronously.

Decomposition:
- lc3b_types package: lc3b_word, lc3b_ipacket, plus a new lc3b_fetch_entry struct {pc, inst}.
- Sub-module fetch_queue: parametrised DEPTH circular FIFO with flush, push, pop, count and head outputs.
- The FSM and PC logic stay in the top module.
- The existing ipacket_creator is reused on the queue head.

Test Plan:
- Reset release with 1-cycle memory, out_ready = 1 -> if_memaddr sequence 0x0000, 0x0002, 0x0004; packets carry matching pc and inst.
- DEPTH = 4, out_ready = 0, memory always responds:
  - After 4 responses (0x0000-0x0006), if_memread = 0 and count = 4.
  - Raising out_ready for 1 cycle -> pc 0x0000 popped and a request for 0x0008 issued.
- 3-cycle memory latency, redirect_valid with target 0x3000 in the 2nd wait cycle:
  - Address 0x0000 held until resp and its data discarded.
  - Next request is 0x3000; queue is empty in between.
- Redirect to 0x1234 in the same cycle as resp -> data dropped, next if_memaddr = 0x1234, packet_valid = 0 the following cycle.
- RESET_PC = 16'hFFFC -> fetches 0xFFFC, 0xFFFE, 0x0000 (wrap).
- rst_n asserted mid-FETCH with count = 3 -> if_memread = 0 and packet_valid = 0 immediately; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_prefetch_stage_pkg.sv
// Shared lc3b fetch-path types: machine word, queue entry, decode packet,
// the fetch FSM encoding and the packet builder applied to the queue head.
package if_prefetch_stage_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned REG_W    = 3;

   typedef logic [WORD_W-1:0]   lc3b_word;
   typedef logic [OPCODE_W-1:0] lc3b_opcode;
   typedef logic [REG_W-1:0]    lc3b_reg;

   // Instructions are word aligned: sequential fetch advances by one word.
   localparam lc3b_word PC_STEP = 16'd2;

   // One prefetch queue slot: the fetch address and the word returned for it.
   typedef struct packed {
      lc3b_word pc;
      lc3b_word inst;
   } lc3b_fetch_entry;

   // Packet handed to decode.
   typedef struct packed {
      lc3b_word   pc;
      lc3b_word   inst;
      lc3b_opcode opcode;
      lc3b_reg    dr;
      lc3b_reg    sr1;
   } lc3b_ipacket;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   // Builds the decode packet from a stored {pc, inst} pair.
   function automatic lc3b_ipacket ipacket_creator(input lc3b_fetch_entry entry);
      lc3b_ipacket p;
      p.pc     = entry.pc;
      p.inst   = entry.inst;
      p.opcode = entry.inst[15:12];
      p.dr     = entry.inst[11:9];
      p.sr1    = entry.inst[8:6];
      return p;
   endfunction

endpackage

// File: rtl/if_prefetch_stage_fetch_queue.sv
// Circular prefetch FIFO of lc3b_fetch_entry slots.
// Ports:
//   clk, rst_n  clock, async active-low reset (pointers and count only)
//   flush       empties the queue at the next edge; overrides push/pop
//   push        write wr_data at the tail
//   pop         retire the head entry
//   wr_data     entry to store
//   head        entry at the read pointer (don't-care when count == 0)
//   count       number of stored entries, 0..DEPTH
// The caller never pushes when full nor pops when empty.
module if_prefetch_stage_fetch_queue
   import if_prefetch_stage_pkg::*;
#(
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            push,
   input  logic            pop,
   input  lc3b_fetch_entry wr_data,
   output lc3b_fetch_entry head,
   output logic [CNT_W-1:0] count
);

   lc3b_fetch_entry  mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Storage: no reset, contents only meaningful below count.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// lc3b instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential word reads (one outstanding) into the queue and presents
// the queue head to decode with valid/ready. A redirect flushes the queue and
// restarts fetch at redirect_target; an in-flight response is dropped.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   redirect_valid      flush and restart fetch at redirect_target
//   redirect_target     new fetch PC
//   out_ready           decode takes the head packet this cycle
//   packet              head packet built from stored {pc, inst}
//   packet_valid        head entry valid (suppressed during a redirect)
//   if_memaddr          registered request address
//   if_memread          read request, held until if_mem_resp
//   if_mem_byte_enable  always both bytes
//   if_mem_resp         one-cycle response strobe
//   if_mem_rdata        read data, valid with if_mem_resp
module if_prefetch_stage
   import if_prefetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter lc3b_word    RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  lc3b_word    redirect_target,
   input  logic        out_ready,
   output lc3b_ipacket packet,
   output logic        packet_valid,
   output lc3b_word    if_memaddr,
   output logic        if_memread,
   output logic [1:0]  if_mem_byte_enable,
   input  logic        if_mem_resp,
   input  lc3b_word    if_mem_rdata
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e     state;
   fetch_state_e     state_n;
   lc3b_word         fpc;
   lc3b_word         fpc_n;
   lc3b_word         req_addr;
   lc3b_word         req_addr_n;
   lc3b_word         next_pc;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             push;
   logic             pop;
   logic             room;
   lc3b_fetch_entry  head;
   lc3b_fetch_entry  wr_entry;

   // Queue handshake terms.
   assign push         = (state == FETCH) && if_mem_resp && !redirect_valid;
   assign packet_valid = (count != '0) && !redirect_valid;
   assign pop          = packet_valid && out_ready;
   assign next_pc      = redirect_valid ? redirect_target : fpc;
   assign wr_entry     = '{pc: req_addr, inst: if_mem_rdata};

   // Occupancy after this edge; a new request launches only if it will fit.
   always_comb begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
      if (redirect_valid) begin
         count_next = '0;
      end
   end

   assign room = (count_next < CNT_W'(DEPTH));

   // State and fetch-PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_n;
         fpc      <= fpc_n;
         req_addr <= req_addr_n;
      end
   end

   // Next-state and PC sequencing.
   always_comb begin
      state_n    = state;
      fpc_n      = fpc;
      req_addr_n = req_addr;
      unique case (state)
         IDLE: begin
            if (room) begin
               req_addr_n = next_pc;
               fpc_n      = next_pc + PC_STEP;
               state_n    = FETCH;
            end else begin
               fpc_n = next_pc;
            end
         end
         FETCH: begin
            if (redirect_valid) begin
               if (if_mem_resp) begin
                  // Response retires the old request; relaunch at the target now.
                  req_addr_n = redirect_target;
                  fpc_n      = redirect_target + PC_STEP;
               end else begin
                  // Request still in flight: wait it out, then fetch the target.
                  fpc_n   = redirect_target;
                  state_n = DISCARD;
               end
            end else if (if_mem_resp) begin
               if (room) begin
                  req_addr_n = fpc;
                  fpc_n      = fpc + PC_STEP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DISCARD: begin
            if (if_mem_resp) begin
               req_addr_n = next_pc;
               fpc_n      = next_pc + PC_STEP;
               state_n    = FETCH;
            end else begin
               fpc_n = next_pc;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   if_prefetch_stage_fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .head    (head),
      .count   (count)
   );

   assign packet             = ipacket_creator(head);
   assign if_memaddr         = req_addr;
   assign if_memread         = (state != IDLE);
   assign if_mem_byte_enable = 2'b11;

endmodule
